// File: rtl/aquila_fifo_pkg.sv
// Shared geometry for the distri_ram based queue controllers.
package aquila_fifo_pkg;
    localparam int FIFO_DEPTH = 32;
    localparam int FIFO_AWDTH = 5;
    localparam int FIFO_CWDTH = 6;
endpackage

// File: rtl/distri_ram.sv
// 32-entry distributed RAM: one synchronous write port, one asynchronous read port.
module distri_ram
    import aquila_fifo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [FIFO_AWDTH-1:0] write_addr_i,
    input  logic [FIFO_AWDTH-1:0] read_addr_i,
    input  logic [XLEN-1:0]       data_i,
    output logic [XLEN-1:0]       data_o
);

    logic [XLEN-1:0] r_mem [0:FIFO_DEPTH-1];

    // Write port; contents are never cleared, so no reset here.
    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[write_addr_i] <= data_i;
    end

    assign data_o = r_mem[read_addr_i];

endmodule

// File: rtl/dram_fifo_ctrl.sv
// First-word-fall-through FIFO controller wrapped around one distri_ram.
// Pointers and count move on identical push/pop conditions, so they stay consistent.
module dram_fifo_ctrl
    import aquila_fifo_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int AF_THRESH = 28
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    input  logic [XLEN-1:0]       s_data_i,
    output logic                  s_ready_o,
    output logic                  m_valid_o,
    output logic [XLEN-1:0]       m_data_o,
    input  logic                  m_ready_i,
    output logic [FIFO_CWDTH-1:0] count_o,
    output logic                  almost_full_o
);

    localparam logic [FIFO_CWDTH-1:0] C_FULL = FIFO_CWDTH'(FIFO_DEPTH);
    localparam logic [FIFO_CWDTH-1:0] C_AF   = FIFO_CWDTH'(AF_THRESH);

    logic [FIFO_AWDTH-1:0] r_wr_ptr;
    logic [FIFO_AWDTH-1:0] r_rd_ptr;
    logic [FIFO_CWDTH-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_we;

    // Flags come straight off the count register, so s_ready_o never sees m_ready_i.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

    assign s_ready_o     = ~w_full;
    assign m_valid_o     = ~w_empty;
    assign count_o       = r_count;
    assign almost_full_o = (r_count >= C_AF);

    assign w_push = s_valid_i & s_ready_o;
    assign w_pop  = m_valid_o & m_ready_i;

    // A flushed or reset cycle must not leave a write behind in the RAM.
    assign w_we = w_push & ~flush_i & ~rst_i;

    // Pointer and occupancy update; reset beats flush, flush beats handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    distri_ram #(
        .XLEN (XLEN)
    ) u_ram (
        .clk_i        (clk_i),
        .we_i         (w_we),
        .write_addr_i (r_wr_ptr),
        .read_addr_i  (r_rd_ptr),
        .data_i       (s_data_i),
        .data_o       (m_data_o)
    );

endmodule

// File: tb/tb_dram_fifo_ctrl.sv
// Directed bench for dram_fifo_ctrl with hand-computed expectations.
module tb_dram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, s_valid_i, m_ready_i;
    logic [31:0] s_data_i;
    logic        s_ready_o, m_valid_o, almost_full_o;
    logic [31:0] m_data_o;
    logic [5:0]  count_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram_fifo_ctrl #(.XLEN(32), .AF_THRESH(28)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_ready_o     (s_ready_o),
        .m_valid_o     (m_valid_o),
        .m_data_o      (m_data_o),
        .m_ready_i     (m_ready_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0; s_data_i = '0;
        tick(); tick();
        chk("rst_ready", 32'(s_ready_o), 32'd1);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_af",    32'(almost_full_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Single push, no same-cycle bypass.
        s_valid_i = 1'b1; s_data_i = 32'hA5A5_0001;
        #1;
        chk("t1_valid_push_cycle", 32'(m_valid_o), 32'd0);
        tick();
        s_valid_i = 1'b0;
        chk("t1_valid", 32'(m_valid_o), 32'd1);
        chk("t1_data",  m_data_o, 32'hA5A5_0001);
        chk("t1_count", 32'(count_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t1_flushed", 32'(count_o), 32'd0);

        // Fill to full, almost-full from 28.
        for (int i = 0; i < 32; i++) begin
            s_valid_i = 1'b1; s_data_i = 32'h100 + 32'(i);
            tick();
            chk("t2_count", 32'(count_o), 32'(i + 1));
            chk("t2_af", 32'(almost_full_o), (i + 1 >= 28) ? 32'd1 : 32'd0);
        end
        chk("t2_ready_full", 32'(s_ready_o), 32'd0);
        s_data_i = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_count", 32'(count_o), 32'd32);
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("t2_drain_data", m_data_o, 32'h100 + 32'(i));
            tick();
        end
        m_ready_i = 1'b0;
        chk("t2_empty_count", 32'(count_o), 32'd0);
        chk("t2_empty_valid", 32'(m_valid_o), 32'd0);

        // Full with simultaneous push and pop: pop only, push one cycle later.
        for (int i = 0; i < 32; i++) begin
            s_valid_i = 1'b1; s_data_i = 32'h200 + 32'(i);
            tick();
        end
        s_data_i = 32'h300; m_ready_i = 1'b1;
        chk("t3_head", m_data_o, 32'h200);
        tick();
        chk("t3_count31", 32'(count_o), 32'd31);
        m_ready_i = 1'b0;
        tick();
        chk("t3_count32", 32'(count_o), 32'd32);
        s_valid_i = 1'b0; m_ready_i = 1'b1;
        for (int i = 1; i < 33; i++) begin
            chk("t3_drain_data", m_data_o, (i == 32) ? 32'h300 : 32'h200 + 32'(i));
            tick();
        end
        m_ready_i = 1'b0;
        chk("t3_empty", 32'(count_o), 32'd0);

        // Steady streaming at depth 5 across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            s_valid_i = 1'b1; s_data_i = 32'h400 + 32'(i);
            tick();
        end
        m_ready_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_data_i = 32'h405 + 32'(k);
            chk("t4_data",  m_data_o, 32'h400 + 32'(k));
            chk("t4_count", 32'(count_o), 32'd5);
            tick();
        end
        s_valid_i = 1'b0; m_ready_i = 1'b0;
        chk("t4_end_count", 32'(count_o), 32'd5);
        chk("t4_end_head",  m_data_o, 32'h428);

        // Flush at 12 with both handshakes active.
        for (int i = 0; i < 7; i++) begin
            s_valid_i = 1'b1; s_data_i = 32'h500 + 32'(i);
            tick();
        end
        chk("t5_count12", 32'(count_o), 32'd12);
        flush_i = 1'b1; m_ready_i = 1'b1; s_data_i = 32'h5FF;
        tick();
        flush_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
        chk("t5_count0", 32'(count_o), 32'd0);
        chk("t5_valid0", 32'(m_valid_o), 32'd0);
        chk("t5_ready1", 32'(s_ready_o), 32'd1);
        s_valid_i = 1'b1; s_data_i = 32'h77;
        tick();
        s_valid_i = 1'b0;
        chk("t5_valid", 32'(m_valid_o), 32'd1);
        chk("t5_data",  m_data_o, 32'h77);
        chk("t5_count1", 32'(count_o), 32'd1);
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        chk("t5_popped", 32'(count_o), 32'd0);

        // Reset mid-stream at 20.
        for (int i = 0; i < 20; i++) begin
            s_valid_i = 1'b1; s_data_i = 32'h600 + 32'(i);
            tick();
        end
        chk("t6_count20", 32'(count_o), 32'd20);
        rst_i = 1'b1; m_ready_i = 1'b1; s_data_i = 32'h700;
        tick();
        rst_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
        chk("t6_rst_count", 32'(count_o), 32'd0);
        chk("t6_rst_valid", 32'(m_valid_o), 32'd0);
        chk("t6_rst_ready", 32'(s_ready_o), 32'd1);
        chk("t6_rst_af",    32'(almost_full_o), 32'd0);
        s_valid_i = 1'b1; s_data_i = 32'h1234;
        tick();
        s_data_i = 32'h1235;
        tick();
        s_valid_i = 1'b0;
        chk("t6_count2", 32'(count_o), 32'd2);
        chk("t6_first",  m_data_o, 32'h1234);
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        chk("t6_second", m_data_o, 32'h1235);
        chk("t6_count1", 32'(count_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_fifo_ctrl.md
Name: dram_fifo_ctrl

Overview:
- Sequences one `distri_ram` instance (32 entries × XLEN, one synchronous write port, one asynchronous read port) as a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Serves as the standard buffering primitive for Aquila-side queues: store buffers, trace/debug queues and UART TX staging.
- Owns the read/write pointers, occupancy count, full/empty/almost-full flags and a synchronous flush.

Parameters:
- XLEN, 32, data word width; passed through to `distri_ram`.
- AF_THRESH, 28, almost_full_o asserts when count ≥ AF_THRESH; legal range 1..32.
- Fixed by the RAM, not a parameter: DEPTH = 32, AWDTH = 5, CWDTH = 6.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous discard of all contents.
- s_valid_i  in  1  producer has a word.
- s_data_i  in  XLEN  producer word.
- s_ready_o  out  1  FIFO can accept a word; equals !full; never depends combinationally on m_ready_i.
- m_valid_o  out  1  head word is valid; equals !empty.
- m_data_o  out  XLEN  head word; combinational RAM read at rd_ptr.
- m_ready_i  in  1  consumer accepts the head word.
- count_o  out  6  occupancy, 0..32.
- almost_full_o  out  1  count_o ≥ AF_THRESH.

Behaviour:
- Internal state:
  - wr_ptr[4:0] and rd_ptr[4:0] wrap modulo 32 with natural 5-bit overflow.
  - count[5:0] is held explicitly; full = (count == 32), empty = (count == 0).
- Handshakes:
  - push = s_valid_i & s_ready_o.
  - pop = m_valid_o & m_ready_i.
- Push:
  - RAM we_i = push, write_addr_i = wr_ptr, data_i = s_data_i.
  - wr_ptr increments on the same posedge.
- Pop: rd_ptr increments on the posedge. RAM read_addr_i = rd_ptr at all times.
- Count update:
  - +1 on push only, −1 on pop only.
  - Unchanged on both or neither.
- Latency:
  - A word pushed into an empty FIFO at edge N shows m_valid_o = 1 and m_data_o = that word in the cycle after edge N.
  - There is no same-cycle bypass.
- Full:
  - s_ready_o = 0, so no push occurs even if the consumer pops in the same cycle.
  - The slot frees one cycle later.
  - A write to a full FIFO is impossible by construction.
- Empty: m_valid_o = 0; m_data_o is don't-care (stale RAM contents); m_ready_i is ignored.
- Simultaneous push and pop with 0 < count < 32: both pointers advance and count is unchanged.
- Flush:
  - At the posedge, wr_ptr, rd_ptr and count go to 0.
  - A push or pop in the same cycle is discarded: no RAM write occurs (we_i is gated by !flush_i).
  - Flush has priority over the handshakes.
  - RAM contents are not cleared.
- Reset:
  - rst_i has the same effect as flush and has priority over it.
  - Any state mid-operation is discarded.
- Output values during and after reset: s_ready_o = 1, m_valid_o = 0, count_o = 0, almost_full_o = 0 (AF_THRESH ≥ 1), m_data_o undefined.
- No illegal states: count and the pointers cannot disagree, because they update on identical conditions.
- All outputs except m_data_o derive from registers only.

Decomposition:
- Shared package `aquila_fifo_pkg`:
  - constants FIFO_DEPTH = 32, FIFO_AWDTH = 5, FIFO_CWDTH = 6.
  - reused by other queue controllers.
- One sub-module: the existing `distri_ram` (XLEN passed through), instantiated once.
- All control logic stays flat in dram_fifo_ctrl; no further split.

Test Plan:
- Reset, then push 0xA5A5_0001 with m_ready_i = 0:
  - next cycle m_valid_o = 1, m_data_o = 0xA5A5_0001, count_o = 1.
  - m_valid_o is 0 in the push cycle itself.
- Push 32 words 0x100..0x11F with no pops:
  - count_o = 32, s_ready_o = 0, almost_full_o = 1 from count 28 onward.
  - 33rd word 0xDEAD is held by the producer and never stored.
  - Drain returns 0x100..0x11F in order.
- Full FIFO, s_valid_i = 1 and m_ready_i = 1 in the same cycle:
  - pop occurs, push refused, count_o = 31.
  - next cycle the push is accepted, count_o = 32.
- Continuous push and pop at count 5 for 40 cycles (pointers wrap past 31):
  - count_o stays 5.
  - output sequence equals input delayed by 5 pops; no reordering at the wrap.
- Flush at count 12 with push and pop asserted in the same cycle:
  - next cycle count_o = 0, m_valid_o = 0.
  - a subsequent push of 0x77 is read back as 0x77.
- rst_i asserted for 1 cycle at count 20 while streaming:
  - all outputs return to their reset values.
  - the next pushed word 0x1234 is the first word popped.
